bus_arb2_rr: RTL and testbench

- Two-master to one-slave arbiter on the team's req/ack/resp bus.
- Sits directly upstream of one port of the dual-port RAM wrapper (bus0 or bus1), e.g. to let the CPU data port and a DMA/debug master share it.
- Round-robin grant, combinational ack passthrough, and an in-order ID FIFO that routes read responses back to the issuing master.

---
 rtl/bus_arb2_rr.sv | 152 +++++++++++++++
 tb/tb_bus_arb2_rr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2_rr.sv
// Two-master to one-slave arbiter for the req/ack/resp bus. Grants round-robin
// (or fixed m0 priority) and routes read responses back through an in-order ID FIFO.
module bus_arb2_rr #(
  parameter int    ID_DEPTH = 4,
  parameter string RR_EN    = "YES"
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      m0_req_i,
  input  logic                      m0_we_i,
  input  logic [31:0]               m0_addr_bi,
  input  logic [31:0]               m0_wdata_bi,
  input  logic [3:0]                m0_be_bi,
  output logic                      m0_ack_o,
  output logic                      m0_resp_o,
  output logic [31:0]               m0_rdata_bo,
  input  logic                      m1_req_i,
  input  logic                      m1_we_i,
  input  logic [31:0]               m1_addr_bi,
  input  logic [31:0]               m1_wdata_bi,
  input  logic [3:0]                m1_be_bi,
  output logic                      m1_ack_o,
  output logic                      m1_resp_o,
  output logic [31:0]               m1_rdata_bo,
  output logic                      s_req_o,
  output logic                      s_we_o,
  output logic [31:0]               s_addr_bo,
  output logic [31:0]               s_wdata_bo,
  output logic [3:0]                s_be_bo,
  input  logic                      s_ack_i,
  input  logic                      s_resp_i,
  input  logic [31:0]               s_rdata_bi,
  output logic                      err_o,
  output logic [$clog2(ID_DEPTH):0] outstanding_o
);

  localparam int            PW      = $clog2(ID_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ID_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam bit            RR_ON   = (RR_EN == "YES");

  logic          id_mem_q [ID_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          prio_q;
  logic          err_q;

  logic full_s;
  logic empty_s;
  logic elig0_s;
  logic elig1_s;
  logic win_vld_s;
  logic win_id_s;
  logic accept_s;
  logic push_s;
  logic pop_s;
  logic head_id_s;

  // Eligibility and winner; the full-block uses registered occupancy only.
  always_comb begin
    full_s    = (cnt_q == DEPTH_C);
    empty_s   = (cnt_q == {CW{1'b0}});
    elig0_s   = m0_req_i & (m0_we_i | ~full_s);
    elig1_s   = m1_req_i & (m1_we_i | ~full_s);
    win_vld_s = (elig0_s | elig1_s) & rst_i;
    if (elig0_s & elig1_s) begin
      win_id_s = RR_ON ? prio_q : 1'b0;
    end else if (elig1_s) begin
      win_id_s = 1'b1;
    end else begin
      win_id_s = 1'b0;
    end
  end

  // Slave-side request mux, zeroed when nobody is granted.
  always_comb begin
    s_req_o    = win_vld_s;
    s_we_o     = 1'b0;
    s_addr_bo  = 32'h0000_0000;
    s_wdata_bo = 32'h0000_0000;
    s_be_bo    = 4'b0000;
    if (win_vld_s && win_id_s) begin
      s_we_o     = m1_we_i;
      s_addr_bo  = m1_addr_bi;
      s_wdata_bo = m1_wdata_bi;
      s_be_bo    = m1_be_bi;
    end else if (win_vld_s) begin
      s_we_o     = m0_we_i;
      s_addr_bo  = m0_addr_bi;
      s_wdata_bo = m0_wdata_bi;
      s_be_bo    = m0_be_bi;
    end else begin
      s_we_o     = 1'b0;
    end
  end

  // Ack passthrough, FIFO events and response routing by the head ID.
  always_comb begin
    accept_s    = win_vld_s & s_ack_i;
    push_s      = accept_s & ~s_we_o;
    pop_s       = s_resp_i & ~empty_s;
    head_id_s   = id_mem_q[rd_ptr_q];
    m0_ack_o    = accept_s & ~win_id_s;
    m1_ack_o    = accept_s & win_id_s;
    m0_resp_o   = pop_s & ~head_id_s;
    m1_resp_o   = pop_s & head_id_s;
    m0_rdata_bo = m0_resp_o ? s_rdata_bi : 32'h0000_0000;
    m1_rdata_bo = m1_resp_o ? s_rdata_bi : 32'h0000_0000;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // ID FIFO, arbitration priority and sticky stray-response flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ID_DEPTH; i++) begin
        id_mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      prio_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push_s) begin
        id_mem_q[wr_ptr_q] <= win_id_s;
        wr_ptr_q           <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (accept_s && RR_ON) begin
        prio_q <= ~win_id_s;
      end
      if (s_resp_i && empty_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o         = err_q;
  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_bus_arb2_rr.sv
// Scoreboard bench for bus_arb2_rr: a queue-based reference model predicts every
// cycle's outputs for a round-robin and a fixed-priority instance sharing inputs.
module tb_bus_arb2_rr;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          m0_ack;
    logic          m1_ack;
    logic          m0_resp;
    logic          m1_resp;
    logic [31:0]   m0_rdata;
    logic [31:0]   m1_rdata;
    logic          s_req;
    logic          s_we;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_be;
    logic          err;
    logic [OW-1:0] outst;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } rec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic m0_req_i = 1'b0, m0_we_i = 1'b0, m1_req_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] m0_addr_bi = 32'h0, m0_wdata_bi = 32'h0, m1_addr_bi = 32'h0, m1_wdata_bi = 32'h0;
  logic [3:0]  m0_be_bi = 4'h0, m1_be_bi = 4'h0;
  logic s_ack_i = 1'b0, s_resp_i = 1'b0;
  logic [31:0] s_rdata_bi = 32'h0;

  obs_t obs_a, obs_b;
  logic [OW-1:0] outst_a, outst_b;

  logic d_rst = 1'b0, d_m0_req = 1'b0, d_m0_we = 1'b0, d_m1_req = 1'b0, d_m1_we = 1'b0;
  logic [31:0] d_m0_addr = 32'h0, d_m0_wdata = 32'h0, d_m1_addr = 32'h0, d_m1_wdata = 32'h0;
  logic [3:0]  d_m0_be = 4'h0, d_m1_be = 4'h0;
  logic d_ack = 1'b0, d_resp = 1'b0;
  logic [31:0] d_rdata = 32'h0;

  int   q_a[$], q_b[$];
  int   prio_a = 0, prio_b = 0;
  bit   err_a = 1'b0, err_b = 1'b0;
  rec_t exp_q[$];
  rec_t last;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  bus_arb2_rr #(.ID_DEPTH(DEPTH), .RR_EN("YES")) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_wdata_bi(m0_wdata_bi),
    .m0_be_bi(m0_be_bi), .m0_ack_o(obs_a.m0_ack), .m0_resp_o(obs_a.m0_resp), .m0_rdata_bo(obs_a.m0_rdata),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_wdata_bi(m1_wdata_bi),
    .m1_be_bi(m1_be_bi), .m1_ack_o(obs_a.m1_ack), .m1_resp_o(obs_a.m1_resp), .m1_rdata_bo(obs_a.m1_rdata),
    .s_req_o(obs_a.s_req), .s_we_o(obs_a.s_we), .s_addr_bo(obs_a.s_addr), .s_wdata_bo(obs_a.s_wdata),
    .s_be_bo(obs_a.s_be), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
    .err_o(obs_a.err), .outstanding_o(outst_a)
  );

  bus_arb2_rr #(.ID_DEPTH(DEPTH), .RR_EN("NO")) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_wdata_bi(m0_wdata_bi),
    .m0_be_bi(m0_be_bi), .m0_ack_o(obs_b.m0_ack), .m0_resp_o(obs_b.m0_resp), .m0_rdata_bo(obs_b.m0_rdata),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_wdata_bi(m1_wdata_bi),
    .m1_be_bi(m1_be_bi), .m1_ack_o(obs_b.m1_ack), .m1_resp_o(obs_b.m1_resp), .m1_rdata_bo(obs_b.m1_rdata),
    .s_req_o(obs_b.s_req), .s_we_o(obs_b.s_we), .s_addr_bo(obs_b.s_addr), .s_wdata_bo(obs_b.s_wdata),
    .s_be_bo(obs_b.s_be), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
    .err_o(obs_b.err), .outstanding_o(outst_b)
  );

  assign obs_a.outst = outst_a;
  assign obs_b.outst = outst_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string t, input obs_t a, input obs_t e);
    chk({t, ".m0_ack"},   64'(a.m0_ack),   64'(e.m0_ack));
    chk({t, ".m1_ack"},   64'(a.m1_ack),   64'(e.m1_ack));
    chk({t, ".m0_resp"},  64'(a.m0_resp),  64'(e.m0_resp));
    chk({t, ".m1_resp"},  64'(a.m1_resp),  64'(e.m1_resp));
    chk({t, ".m0_rdata"}, 64'(a.m0_rdata), 64'(e.m0_rdata));
    chk({t, ".m1_rdata"}, 64'(a.m1_rdata), 64'(e.m1_rdata));
    chk({t, ".s_req"},    64'(a.s_req),    64'(e.s_req));
    chk({t, ".s_we"},     64'(a.s_we),     64'(e.s_we));
    chk({t, ".s_addr"},   64'(a.s_addr),   64'(e.s_addr));
    chk({t, ".s_wdata"},  64'(a.s_wdata),  64'(e.s_wdata));
    chk({t, ".s_be"},     64'(a.s_be),     64'(e.s_be));
    chk({t, ".err"},      64'(a.err),      64'(e.err));
    chk({t, ".outst"},    64'(a.outst),    64'(e.outst));
  endtask

  // Reference: outstanding reads as a list of master IDs, priority as a master number.
  task automatic model_step(input bit rr, ref int q[$], ref int prio, ref bit err, output obs_t e);
    bit full, e0, e1;
    int win, id;
    e = '0;
    if (!rst_i) begin
      q.delete();
      prio = 0;
      err  = 1'b0;
      return;
    end
    full = (q.size() == DEPTH);
    e0   = m0_req_i && (m0_we_i || !full);
    e1   = m1_req_i && (m1_we_i || !full);
    win  = -1;
    if (e0 && e1) win = rr ? prio : 0;
    else if (e0)  win = 0;
    else if (e1)  win = 1;
    e.outst = OW'(q.size());
    e.err   = err;
    if (win >= 0) begin
      e.s_req   = 1'b1;
      e.s_we    = (win == 1) ? m1_we_i    : m0_we_i;
      e.s_addr  = (win == 1) ? m1_addr_bi : m0_addr_bi;
      e.s_wdata = (win == 1) ? m1_wdata_bi : m0_wdata_bi;
      e.s_be    = (win == 1) ? m1_be_bi   : m0_be_bi;
      e.m0_ack  = s_ack_i && (win == 0);
      e.m1_ack  = s_ack_i && (win == 1);
    end
    if (s_resp_i) begin
      if (q.size() > 0) begin
        id = q.pop_front();
        if (id == 0) begin e.m0_resp = 1'b1; e.m0_rdata = s_rdata_bi; end
        else         begin e.m1_resp = 1'b1; e.m1_rdata = s_rdata_bi; end
      end else begin
        err = 1'b1;
      end
    end
    if (win >= 0 && s_ack_i) begin
      if (rr) prio = 1 - win;
      if (!e.s_we) q.push_back(win);
    end
  endtask

  task automatic step();
    rec_t r;
    @(negedge clk_i);
    rst_i = d_rst;
    m0_req_i = d_m0_req; m0_we_i = d_m0_we; m0_addr_bi = d_m0_addr; m0_wdata_bi = d_m0_wdata; m0_be_bi = d_m0_be;
    m1_req_i = d_m1_req; m1_we_i = d_m1_we; m1_addr_bi = d_m1_addr; m1_wdata_bi = d_m1_wdata; m1_be_bi = d_m1_be;
    s_ack_i = d_ack; s_resp_i = d_resp; s_rdata_bi = d_rdata;
    model_step(1'b1, q_a, prio_a, err_a, r.a);
    model_step(1'b0, q_b, prio_b, err_b, r.b);
    exp_q.push_back(r);
    last = r;
  endtask

  task automatic idle_inputs();
    d_m0_req = 1'b0; d_m1_req = 1'b0; d_ack = 1'b0; d_resp = 1'b0; d_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    d_rst = 1'b0; step();
    d_rst = 1'b1; step();
  endtask

  task automatic set_m0(input logic we, input logic [31:0] addr, input logic [3:0] be);
    d_m0_req = 1'b1; d_m0_we = we; d_m0_addr = addr; d_m0_wdata = ~addr; d_m0_be = be;
  endtask

  task automatic set_m1(input logic we, input logic [31:0] addr, input logic [3:0] be);
    d_m1_req = 1'b1; d_m1_we = we; d_m1_addr = addr; d_m1_wdata = ~addr; d_m1_be = be;
  endtask

  // Monitor: each cycle the DUT outputs are compared against the oldest prediction.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check_obs("rr", obs_a, r.a);
        check_obs("fp", obs_b, r.b);
      end
    end
  end

  initial begin
    bit p0, p1;
    do_reset();
    #2;
    chk("reset.outst", 64'(outst_a), 64'd0);
    chk("reset.err", 64'(obs_a.err), 64'd0);

    // Single read with one-cycle response.
    set_m0(1'b0, 32'h10, 4'hF); d_ack = 1'b1; step(); #2;
    chk("t1.m0_ack", 64'(obs_a.m0_ack), 64'd1);
    idle_inputs(); d_resp = 1'b1; d_rdata = 32'hDEADBEEF; step(); #2;
    chk("t1.m0_resp", 64'(obs_a.m0_resp), 64'd1);
    chk("t1.m0_rdata", 64'(obs_a.m0_rdata), 64'hDEADBEEF);
    chk("t1.m1_resp", 64'(obs_a.m1_resp), 64'd0);
    chk("t1.outst", 64'(outst_a), 64'd1);

    // Contending reads alternate under round-robin, m0 always wins when fixed.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_m0(1'b0, 32'h100, 4'hF); set_m1(1'b0, 32'h200, 4'hF); d_ack = 1'b1; step(); #2;
      chk("t2.rr_m0_ack", 64'(obs_a.m0_ack), 64'((i % 2) == 0));
      chk("t2.fp_m0_ack", 64'(obs_b.m0_ack), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); d_resp = 1'b1; d_rdata = 32'hA0 + 32'(i); step(); #2;
      chk("t2.rr_m0_resp", 64'(obs_a.m0_resp), 64'((i % 2) == 0));
      chk("t2.rr_m1_resp", 64'(obs_a.m1_resp), 64'((i % 2) == 1));
      chk("t2.fp_m0_resp", 64'(obs_b.m0_resp), 64'd1);
    end

    // Write stalled by the slave keeps its grant and byte enables.
    do_reset();
    set_m1(1'b1, 32'h44, 4'b0010); d_ack = 1'b0; step(); #2;
    chk("t3.m1_ack_stall", 64'(obs_a.m1_ack), 64'd0);
    chk("t3.s_be_stall", 64'(obs_a.s_be), 64'h2);
    d_ack = 1'b1; step(); #2;
    chk("t3.m1_ack", 64'(obs_a.m1_ack), 64'd1);
    chk("t3.s_be", 64'(obs_a.s_be), 64'h2);
    set_m0(1'b0, 32'h48, 4'hF); set_m1(1'b0, 32'h4C, 4'hF); step(); #2;
    chk("t3.outst_after_write", 64'(outst_a), 64'd0);
    chk("t3.m0_wins_after_flip", 64'(obs_a.m0_ack), 64'd1);

    // Full FIFO blocks reads but not writes; a pop admits a read next cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_m0(1'b0, 32'h80 + 32'(i), 4'hF); d_ack = 1'b1; step();
    end
    set_m0(1'b0, 32'h90, 4'hF); set_m1(1'b1, 32'h94, 4'h3); step(); #2;
    chk("t4.outst_full", 64'(outst_a), 64'd4);
    chk("t4.m1_write_ack", 64'(obs_a.m1_ack), 64'd1);
    chk("t4.m0_blocked", 64'(obs_a.m0_ack), 64'd0);
    d_m1_req = 1'b0; step(); #2;
    chk("t4.s_req_blocked", 64'(obs_a.s_req), 64'd0);
    d_resp = 1'b1; d_rdata = 32'h5555; step(); #2;
    chk("t4.m0_still_blocked", 64'(obs_a.m0_ack), 64'd0);
    d_resp = 1'b0; step(); #2;
    chk("t4.m0_admitted", 64'(obs_a.m0_ack), 64'd1);

    // Stray response sets the sticky error.
    do_reset();
    d_resp = 1'b1; d_rdata = 32'h1234; step(); #2;
    chk("t5.m0_resp", 64'(obs_a.m0_resp), 64'd0);
    chk("t5.m1_resp", 64'(obs_a.m1_resp), 64'd0);
    d_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      chk("t5.err_sticky", 64'(obs_a.err), 64'd1);
    end

    // Asynchronous reset between edges with two reads outstanding.
    do_reset();
    set_m0(1'b0, 32'hC0, 4'hF); set_m1(1'b0, 32'hC4, 4'hF); d_ack = 1'b1; step(); step();
    @(posedge clk_i); #2;
    s_resp_i = 1'b1; rst_i = 1'b0; d_rst = 1'b0;
    q_a.delete(); q_b.delete(); prio_a = 0; prio_b = 0; err_a = 1'b0; err_b = 1'b0;
    #1;
    chk("t6.s_req", 64'(obs_a.s_req), 64'd0);
    chk("t6.m0_resp", 64'(obs_a.m0_resp), 64'd0);
    chk("t6.m1_resp", 64'(obs_a.m1_resp), 64'd0);
    chk("t6.outst", 64'(outst_a), 64'd0);
    chk("t6.err", 64'(obs_a.err), 64'd0);
    step();
    idle_inputs(); d_rst = 1'b1; d_resp = 1'b1; step();
    d_resp = 1'b0; set_m0(1'b0, 32'hD0, 4'hF); set_m1(1'b0, 32'hD4, 4'hF); d_ack = 1'b1; step(); #2;
    chk("t6.late_err", 64'(obs_a.err), 64'd1);
    chk("t6.prio_m0", 64'(obs_a.m0_ack), 64'd1);

    // Randomised traffic; masters hold their request until the predicted ack.
    do_reset();
    p0 = 1'b0; p1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; set_m0($urandom_range(0, 2) == 0, $urandom, 4'($urandom)); d_m0_wdata = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; set_m1($urandom_range(0, 2) == 0, $urandom, 4'($urandom)); d_m1_wdata = $urandom;
      end
      d_m0_req = p0; d_m1_req = p1;
      d_ack   = ($urandom_range(0, 3) != 0);
      d_resp  = (q_a.size() > 0) && ($urandom_range(0, 2) == 0);
      d_rdata = $urandom;
      step();
      if (last.a.m0_ack) p0 = 1'b0;
      if (last.a.m1_ack) p1 = 1'b0;
    end
    idle_inputs(); step(); step();
    @(negedge clk_i); #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
